rv32_muldiv_unit: RTL and testbench
===================================

Name: rv32_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the execute stage of Hunter_RV32.
- Accepts one M-extension op at a time and stalls the pipeline while busy.
- Drives a result word into the writeback-select 4:1 multiplexer alongside the ALU, memory and PC+4 sources.
- Radix-2 algorithms: one operand bit per cycle, shared accumulator/shift datapath for multiply and divide.

Parameters:
- XLEN, 32: operand and result width; iteration count equals XLEN.

Ports:
- clk  input  1  core clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  op request; sampled only in IDLE or DONE
- flush  input  1  pipeline kill; aborts any op in flight
- funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1  input  XLEN  operand A / dividend
- rs2  input  XLEN  operand B / divisor
- busy  output  1  high in RUN and FIX; used by hazard unit to stall
- done  output  1  one-cycle pulse, result valid
- result  output  XLEN  registered result; holds until next completion

Behaviour:
- Reset: state=IDLE, busy=0, done=0, result=0, all internal registers 0.
- rst has priority over flush; flush has priority over start.
- States: IDLE, RUN, FIX, DONE.
- Start acceptance:
  - IDLE or DONE with start=1 and flush=0: latch funct3, operand signs and operand magnitudes.
  - Go to RUN with iteration counter = XLEN-1.
  - Special cases below go directly to DONE instead.
- Signedness:
  - MUL, MULH, DIV and REM treat both operands as signed.
  - MULHSU treats rs1 as signed and rs2 as unsigned.
  - MULHU, DIVU and REMU treat both operands as unsigned.
- RUN (exactly XLEN cycles, counter decrements, exit at 0):
  - Multiply: shift-add on magnitudes into a 2*XLEN-bit product.
  - Divide: restoring, one quotient bit per cycle, XLEN+1-bit partial remainder.
- FIX (1 cycle):
  - Negate the product if the operand signs differ (signed cases only).
  - Negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Select the low or high product half, or the quotient or remainder, and register it into result.
- DONE (1 cycle):
  - done=1, busy=0.
  - Next state is IDLE, or RUN/DONE if a new start is accepted this cycle (back-to-back, no bubble).
- Latency: start sampled at edge T -> done=1 in cycle T+XLEN+2 (34 for XLEN=32).
- Special cases (no RUN, result written at edge T, done=1 in cycle T+1):
  - Divisor zero: DIV/DIVU -> all ones; REM/REMU -> rs1.
  - Signed overflow, DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF: DIV -> 0x80000000; REM -> 0.
- start while busy=1 is ignored; the bench asserts the pipeline never does this.
- flush in RUN or FIX:
  - Next state IDLE, busy=0, no done pulse, result unchanged.
  - Operands discarded.
- flush in DONE: done still pulses this cycle (result already committed); any start in that cycle is dropped.
- rst mid-operation: same as flush, plus result cleared to 0.
- Operand registers are not re-sampled during RUN; input changes while busy have no effect.

Decomposition:
- Shared package rv32_pkg:
  - RV32M funct3 localparams: F3_MUL through F3_REMU.
  - State encoding: IDLE=2'd0, RUN=2'd1, FIX=2'd2, DONE=2'd3.
  - XLEN default.
- One sub-module, muldiv_iter_core: accumulator, shift registers, add/subtract step and counter, controlled by load/step signals from the top-level FSM.
- Sign handling, special-case detection and result selection stay in rv32_muldiv_unit.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (-3) -> result 0xFFFFFFEB, done exactly in cycle T+34, busy high cycles T+1..T+33.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF with done in cycle T+1; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Start MUL 3*4, pulse flush in RUN cycle 10 -> busy=0 next cycle, no done, result keeps prior value. Then start DIVU 9/3 -> 3. start pulses during busy are ignored.
- Back-to-back: new start in a DONE cycle (MUL 2*3 then MUL 5*5) -> results 6 then 25, no idle bubble. rst asserted in RUN cycle 5 -> all outputs 0 next cycle.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared definitions for the Hunter_RV32 execute-stage M-extension unit.
package rv32_pkg;

   localparam int XLEN_DEFAULT = 32;

   // RV32M funct3 encodings
   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } md_state_t;

endpackage

// File: rtl/muldiv_iter_core.sv
// Radix-2 iterative datapath shared by multiply (shift-add) and divide
// (restoring). acc holds the product high half / partial remainder, shreg
// holds the multiplier->product low half / dividend->quotient.
module muldiv_iter_core
   import rv32_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clr,
   input  logic            load,
   input  logic            step,
   input  logic            is_div,
   input  logic [XLEN-1:0] a_mag,
   input  logic [XLEN-1:0] b_mag,
   output logic            last,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   localparam int CW = $clog2(XLEN);

   logic [XLEN-1:0] acc;
   logic [XLEN-1:0] shreg;
   logic [XLEN-1:0] opb;
   logic [CW-1:0]   cnt;

   logic [XLEN:0]   sum;
   logic [XLEN:0]   shifted;
   logic [XLEN:0]   diff;

   // One iteration step: add-and-shift for multiply, trial subtract for divide
   always_comb begin
      sum     = {1'b0, acc} + (shreg[0] ? {1'b0, opb} : '0);
      shifted = {acc, shreg[XLEN-1]};
      diff    = shifted - {1'b0, opb};
   end

   // Iteration registers: load operands, then advance one bit per step
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         acc   <= '0;
         shreg <= '0;
         opb   <= '0;
         cnt   <= '0;
      end else if (load) begin
         acc   <= '0;
         shreg <= a_mag;
         opb   <= b_mag;
         cnt   <= CW'(XLEN - 1);
      end else if (step) begin
         if (is_div) begin
            // restoring: keep the difference only when it did not go negative
            acc   <= diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
            shreg <= {shreg[XLEN-2:0], ~diff[XLEN]};
         end else begin
            acc   <= sum[XLEN:1];
            shreg <= {sum[0], shreg[XLEN-1:1]};
         end
         if (cnt != '0) cnt <= cnt - 1'b1;
      end
   end

   assign last = (cnt == '0);
   assign hi   = acc;
   assign lo   = shreg;

endmodule

// File: rtl/rv32_muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Operates on magnitudes in the core,
// applies signs and selects the result half in a single FIX cycle.
module rv32_muldiv_unit
   import rv32_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            flush,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   md_state_t state, state_nxt;

   logic [2:0]      op;
   logic            neg_a, neg_b;

   logic            a_sgn, b_sgn, a_neg, b_neg;
   logic [XLEN-1:0] a_mag, b_mag;
   logic            div_zero, div_ovf, special;
   logic [XLEN-1:0] spec_val;

   logic            load, step, clr, last;
   logic [XLEN-1:0] hi, lo;

   logic [2*XLEN-1:0] prod, prod_fix;
   logic [XLEN-1:0]   fix_val;
   logic              res_we;
   logic [XLEN-1:0]   res_nxt;

   function automatic logic [XLEN-1:0] neg_if(input logic n, input logic [XLEN-1:0] v);
      return n ? (XLEN'(0) - v) : v;
   endfunction

   muldiv_iter_core #(.XLEN(XLEN)) u_core (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr),
      .load   (load),
      .step   (step),
      .is_div (op[2] | (load & funct3[2])),
      .a_mag  (a_mag),
      .b_mag  (b_mag),
      .last   (last),
      .hi     (hi),
      .lo     (lo)
   );

   // Decode the incoming request: signedness, magnitudes and special cases
   always_comb begin
      a_sgn    = (funct3 == F3_MUL) || (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                 (funct3 == F3_DIV) || (funct3 == F3_REM);
      b_sgn    = (funct3 == F3_MUL) || (funct3 == F3_MULH) ||
                 (funct3 == F3_DIV) || (funct3 == F3_REM);
      a_neg    = a_sgn & rs1[XLEN-1];
      b_neg    = b_sgn & rs2[XLEN-1];
      a_mag    = neg_if(a_neg, rs1);
      b_mag    = neg_if(b_neg, rs2);
      div_zero = funct3[2] && (rs2 == '0);
      div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                 (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
      special  = div_zero | div_ovf;
      if (div_zero) spec_val = funct3[1] ? rs1 : '1;
      else          spec_val = funct3[1] ? '0 : rs1;
   end

   // Sign fix-up and result selection from the finished iteration
   always_comb begin
      prod     = {hi, lo};
      prod_fix = (neg_a ^ neg_b) ? ((2*XLEN)'(0) - prod) : prod;
      case (op)
         F3_MUL:                     fix_val = prod_fix[XLEN-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU: fix_val = prod_fix[2*XLEN-1:XLEN];
         F3_DIV, F3_DIVU:            fix_val = neg_if(neg_a ^ neg_b, lo);
         default:                    fix_val = neg_if(neg_a, hi);
      endcase
   end

   // Next-state and control decode
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      clr       = 1'b0;
      res_we    = 1'b0;
      res_nxt   = fix_val;
      case (state)
         IDLE, DONE: begin
            state_nxt = IDLE;
            if (start && !flush) begin
               if (special) begin
                  state_nxt = DONE;
                  res_we    = 1'b1;
                  res_nxt   = spec_val;
               end else begin
                  state_nxt = RUN;
                  load      = 1'b1;
               end
            end
         end
         RUN: begin
            if (flush) begin
               state_nxt = IDLE;
               clr       = 1'b1;
            end else begin
               step = 1'b1;
               if (last) state_nxt = FIX;
            end
         end
         FIX: begin
            if (flush) begin
               state_nxt = IDLE;
               clr       = 1'b1;
            end else begin
               res_we    = 1'b1;
               state_nxt = DONE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, latched op/sign flags and the result register
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         op     <= '0;
         neg_a  <= 1'b0;
         neg_b  <= 1'b0;
         result <= '0;
      end else begin
         state <= state_nxt;
         if (clr) begin
            op    <= '0;
            neg_a <= 1'b0;
            neg_b <= 1'b0;
         end else if (load) begin
            op    <= funct3;
            neg_a <= a_neg;
            neg_b <= b_neg;
         end
         if (res_we) result <= res_nxt;
      end
   end

   assign busy = (state == RUN) || (state == FIX);
   assign done = (state == DONE);

endmodule

// File: tb/tb_rv32_muldiv_unit.sv
// Scoreboard bench for rv32_muldiv_unit: directed RV32M vectors, special
// cases, flush/reset aborts and back-to-back issue.
module tb_rv32_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        flush;
   logic [2:0]  funct3;
   logic [31:0] rs1, rs2;
   logic        busy, done;
   logic [31:0] result;

   typedef struct {
      logic [31:0] val;
      int          edge_n;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   cyc  = 0;
   int   nvec = 0;
   int   nmis = 0;

   // latency in clock edges after the sampling edge at which done is seen
   localparam int LAT_RUN  = 33;
   localparam int LAT_SPEC = 0;

   rv32_muldiv_unit #(.XLEN(32)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .flush  (flush),
      .funct3 (funct3),
      .rs1    (rs1),
      .rs2    (rs2),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every done pulse must match the oldest expected result
   always @(negedge clk) begin
      if (!rst && done) begin
         if (sb.size() == 0) begin
            nvec++;
            nmis++;
            $display("FAIL unexpected_done: got done at edge %0d result=%08h, required no done", cyc, result);
         end else begin
            exp_t e;
            e = sb.pop_front();
            nvec++;
            if (result !== e.val) begin
               nmis++;
               $display("FAIL %s result: got %08h, required %08h", e.name, result, e.val);
            end
            nvec++;
            if (cyc != e.edge_n) begin
               nmis++;
               $display("FAIL %s latency: done at edge %0d, required edge %0d", e.name, cyc, e.edge_n);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      nvec++;
      if (act !== req) begin
         nmis++;
         $display("FAIL %s: got %08h, required %08h", nm, act, req);
      end
   endtask

   // Called at a negedge; drives a one-cycle start sampled at the next edge
   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ev, input int lat, input bit track, input string nm);
      exp_t e;
      funct3 = f;
      rs1    = a;
      rs2    = b;
      start  = 1'b1;
      if (track) begin
         e.val    = ev;
         e.edge_n = cyc + 1 + lat;
         e.name   = nm;
         sb.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 100; i++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      if (sb.size() != 0) begin
         nvec++;
         nmis++;
         $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
         sb.delete();
      end
      @(negedge clk);
      @(negedge clk);
   endtask

   typedef struct {
      logic [2:0]  f;
      logic [31:0] a, b, r;
      int          lat;
      string       nm;
   } vec_t;

   initial begin
      vec_t vecs[$];
      int   bcnt;

      rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0;
      repeat (3) @(negedge clk);
      chk("reset_busy",   {31'd0, busy}, 32'd0);
      chk("reset_done",   {31'd0, done}, 32'd0);
      chk("reset_result", result,        32'd0);
      rst = 1'b0;
      @(negedge clk);

      // MUL with busy window count
      issue(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT_RUN, 1'b1, "mul_7_m3");
      bcnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) break;
         if (busy) bcnt++;
         @(negedge clk);
      end
      chk("mul_busy_cycles", bcnt, 32'd33);
      drain();

      vecs = '{
         '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT_RUN, "mulh_min_min"},
         '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_RUN, "mulhu_max"},
         '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT_RUN, "mulhsu_m1_max"},
         '{3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, LAT_RUN, "div_m7_2"},
         '{3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, LAT_RUN, "rem_m7_2"},
         '{3'b101, 32'd100,       32'd7,         32'd14,        LAT_RUN, "divu_100_7"},
         '{3'b111, 32'd100,       32'd7,         32'd2,         LAT_RUN, "remu_100_7"}
      };
      foreach (vecs[i]) begin
         issue(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].lat, 1'b1, vecs[i].nm);
         drain();
      end

      // Flush in RUN cycle 10: no done, result keeps 2
      issue(3'b000, 32'd3, 32'd4, 32'd0, LAT_RUN, 1'b0, "");
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_busy",   {31'd0, busy}, 32'd0);
      chk("flush_done",   {31'd0, done}, 32'd0);
      chk("flush_result", result,        32'd2);
      repeat (40) @(negedge clk);

      // DIVU with start pulses while busy that must be ignored
      issue(3'b101, 32'd9, 32'd3, 32'd3, LAT_RUN, 1'b1, "divu_9_3");
      repeat (3) @(negedge clk);
      funct3 = 3'b000; rs1 = 32'd55; rs2 = 32'd66; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      funct3 = 3'b100; rs1 = 32'd1; rs2 = 32'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      drain();

      vecs = '{
         '{3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, LAT_SPEC, "div_5_0"},
         '{3'b111, 32'd5,         32'd0,         32'd5,         LAT_SPEC, "remu_5_0"},
         '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SPEC, "div_ovf"},
         '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         LAT_SPEC, "rem_ovf"}
      };
      foreach (vecs[i]) begin
         issue(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].lat, 1'b1, vecs[i].nm);
         drain();
      end

      // Back-to-back: second start issued in the DONE cycle of the first
      issue(3'b000, 32'd2, 32'd3, 32'd6, LAT_RUN, 1'b1, "mul_2_3");
      for (int i = 0; i < 40; i++) begin
         if (done) break;
         @(negedge clk);
      end
      issue(3'b000, 32'd5, 32'd5, 32'd25, LAT_RUN, 1'b1, "mul_5_5_b2b");
      drain();

      // Reset in RUN cycle 5 clears everything
      issue(3'b000, 32'd9, 32'd9, 32'd0, LAT_RUN, 1'b0, "");
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_busy",   {31'd0, busy}, 32'd0);
      chk("rst_mid_done",   {31'd0, done}, 32'd0);
      chk("rst_mid_result", result,        32'd0);
      rst = 1'b0;
      repeat (40) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit, required completion");
      $fatal(1);
   end

endmodule
